// File: rtl/seg_scan_bcd_if.sv
// Value-transfer handshake between a CPU output register and the 7-segment scan driver.
// The master presents a value with its format flags; the slave accepts it while idle.
interface seg_scan_bcd_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_signed;
   logic              blank_lz;

   modport master (output in_valid, in_data, in_signed, blank_lz, input in_ready);
   modport slave  (input in_valid, in_data, in_signed, blank_lz, output in_ready);
endinterface

// File: rtl/seg_scan_bcd.sv
// Multiplexed 7-segment driver: sequential double-dabble BCD conversion (signed or
// unsigned) with leading-zero blanking, overflow dashes and a free-running digit scan.
module seg_scan_bcd #(
   parameter int DIGITS   = 4,
   parameter int DATA_W   = 8,
   parameter int SCAN_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_bcd_if.slave     in_if,
   output logic [DIGITS-1:0] ena,
   output logic [7:0]        light,
   output logic              ovf
);
   localparam int BW    = 4 * DIGITS;
   localparam int BIT_W = $clog2(DATA_W);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   typedef enum logic [1:0] {IDLE, ABS, CONV, DONE} state_t;

   state_t                   state, state_nxt;
   logic [DATA_W-1:0]        data_q, mag_q;
   logic                     signed_q, blank_q, neg_q, ovf_int;
   logic [BW-1:0]            bcd_q, bcd_adj;
   logic [BIT_W-1:0]         bit_cnt;
   logic [DIGITS-1:0][3:0]   digit_q, digit_nxt;
   logic                     disp_ovf;
   logic [CNT_W-1:0]         cnt;
   logic [IDX_W-1:0]         idx;
   int                       m;

   function automatic logic [7:0] glyph(input logic [3:0] code);
      case (code)
         4'd0:    glyph = 8'hFC;
         4'd1:    glyph = 8'h60;
         4'd2:    glyph = 8'hDA;
         4'd3:    glyph = 8'hF2;
         4'd4:    glyph = 8'h66;
         4'd5:    glyph = 8'hB6;
         4'd6:    glyph = 8'hBE;
         4'd7:    glyph = 8'hE0;
         4'd8:    glyph = 8'hFE;
         4'd9:    glyph = 8'hE6;
         4'd10:   glyph = 8'h02;
         default: glyph = 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      in_if.in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_if.in_ready = 1'b1;
            if (in_if.in_valid) state_nxt = ABS;
         end
         ABS:  state_nxt = CONV;
         CONV: if (bit_cnt == BIT_W'(DATA_W - 1)) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Double-dabble correction step applied before every shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
   end

   // Display codes for the finished conversion; m is the highest nonzero nibble.
   always_comb begin
      m         = 0;
      digit_nxt = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] != 4'd0) m = k;
      end
      disp_ovf = ovf_int || (neg_q && (bcd_q[BW-1 -: 4] != 4'd0));
      for (int k = 0; k < DIGITS; k++) begin
         digit_nxt[k] = bcd_q[4*k +: 4];
         if (disp_ovf) begin
            digit_nxt[k] = CODE_DASH;
         end else if (blank_q) begin
            if (neg_q && (k == m + 1)) digit_nxt[k] = CODE_DASH;
            else if (k > m)            digit_nxt[k] = CODE_BLANK;
         end else if (neg_q && (k == DIGITS - 1)) begin
            digit_nxt[k] = CODE_DASH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         signed_q <= 1'b0;
         blank_q  <= 1'b0;
         neg_q    <= 1'b0;
         mag_q    <= '0;
         bcd_q    <= '0;
         ovf_int  <= 1'b0;
         bit_cnt  <= '0;
         digit_q  <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_if.in_valid) begin
               data_q   <= in_if.in_data;
               signed_q <= in_if.in_signed;
               blank_q  <= in_if.blank_lz;
            end
            ABS: begin
               neg_q   <= signed_q && data_q[DATA_W-1];
               mag_q   <= (signed_q && data_q[DATA_W-1]) ? -data_q : data_q;
               bcd_q   <= '0;
               ovf_int <= 1'b0;
               bit_cnt <= '0;
            end
            CONV: begin
               bcd_q   <= {bcd_adj[BW-2:0], mag_q[DATA_W-1]};
               mag_q   <= {mag_q[DATA_W-2:0], 1'b0};
               ovf_int <= ovf_int | bcd_adj[BW-1];
               bit_cnt <= bit_cnt + 1'b1;
            end
            DONE: begin
               digit_q <= digit_nxt;
               ovf     <= disp_ovf;
            end
            default: ;
         endcase
      end
   end

   // Scan keeps running regardless of conversions so the display never flickers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
         cnt <= '0;
         idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign ena   = DIGITS'(1) << idx;
   assign light = glyph(digit_q[idx]);
endmodule
